mem_bus_arbiter: RTL and testbench

Two-master, one-slave arbiter for the PicoRV32 native memory bus. It shares the system RAM/IO port between the CPU core (master 0) and a program loader/debug master (master 1). Requests are granted round-robin, and each granted request is forwarded as a registered, single-outstanding transaction. A watchdog terminates any slave access that stalls and flags an error to the owning master.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/rr_pick2.sv | 22 ++
 rtl/mem_bus_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master PicoRV32 memory bus arbiter.
package mem_arb_pkg;

    // Arbiter transaction phases.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Master indices: the CPU core and the program loader / debug master.
    localparam int M_CPU    = 0;
    localparam int M_LOADER = 1;

    // Default number of cycles to wait for the slave before giving up.
    localparam int DEFAULT_TIMEOUT = 255;

    // One-hot vector for a master index (0 -> 01, 1 -> 10).
    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester wins, a tie
// goes to the master that was not served last.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Select the winner from the request pair and the last-served index.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = owner_onehot(~last);
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave arbiter for the PicoRV32 native memory bus with a
// registered single-outstanding slave request and a stall watchdog.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_valid,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_ready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_err,
    input  logic                m1_valid,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_ready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_err,
    output logic                s_valid,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_ready,
    input  logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          grant
);

    localparam int STRB_W = DATA_W / 8;
    // Counter only needs to reach TIMEOUT; it saturates there.
    localparam int              CNT_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic            TIMEOUT_EN  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    arb_state_e          state_r, state_nxt_s;
    logic [1:0]          req_s, pick_s, grant_r, ready_r;
    logic                owner_r, last_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                grant_now_s, finish_s, timeout_hit_s;
    logic                s_valid_r;
    logic [ADDR_W-1:0]   s_addr_r;
    logic [DATA_W-1:0]   s_wdata_r, m0_rdata_r, m1_rdata_r;
    logic [STRB_W-1:0]   s_wstrb_r;
    logic                m0_err_r, m1_err_r;

    assign req_s = {m1_valid, m0_valid};

    rr_pick2 u_pick (
        .req  (req_s),
        .last (last_r),
        .gnt  (pick_s)
    );

    // Next-state and per-cycle decisions (grant, completion, timeout).
    always_comb begin
        state_nxt_s   = state_r;
        grant_now_s   = 1'b0;
        finish_s      = 1'b0;
        timeout_hit_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (|req_s) begin
                    grant_now_s = 1'b1;
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                // A slave response in the same cycle as expiry takes priority.
                if (s_ready) begin
                    finish_s    = 1'b1;
                    state_nxt_s = RESP;
                end else if (TIMEOUT_EN && (cnt_r == TIMEOUT_CNT)) begin
                    finish_s      = 1'b1;
                    timeout_hit_s = 1'b1;
                    state_nxt_s   = RESP;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Slave request and payload: latched at grant, held until completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_valid_r <= 1'b0;
            s_addr_r  <= {ADDR_W{1'b0}};
            s_wdata_r <= {DATA_W{1'b0}};
            s_wstrb_r <= {STRB_W{1'b0}};
        end else if (grant_now_s) begin
            s_valid_r <= 1'b1;
            if (pick_s[M_LOADER]) begin
                s_addr_r  <= m1_addr;
                s_wdata_r <= m1_wdata;
                s_wstrb_r <= m1_wstrb;
            end else begin
                s_addr_r  <= m0_addr;
                s_wdata_r <= m0_wdata;
                s_wstrb_r <= m0_wstrb;
            end
        end else if (finish_s) begin
            s_valid_r <= 1'b0;
        end
    end

    // Ownership, round-robin history and saturating watchdog counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_r <= 2'b00;
            owner_r <= 1'b0;
            last_r  <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (grant_now_s) begin
            grant_r <= pick_s;
            owner_r <= pick_s[M_LOADER];
            cnt_r   <= {CNT_W{1'b0}};
        end else if (state_r == RESP) begin
            grant_r <= 2'b00;
            last_r  <= owner_r;
        end else if ((state_r == BUSY) && TIMEOUT_EN && (cnt_r != TIMEOUT_CNT)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Completion pulse and response data/error for the owning master.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_r    <= 2'b00;
            m0_rdata_r <= {DATA_W{1'b0}};
            m1_rdata_r <= {DATA_W{1'b0}};
            m0_err_r   <= 1'b0;
            m1_err_r   <= 1'b0;
        end else begin
            ready_r <= 2'b00;
            if (finish_s) begin
                ready_r <= owner_onehot(owner_r);
                if (owner_r) begin
                    m1_rdata_r <= s_ready ? s_rdata : {DATA_W{1'b0}};
                    m1_err_r   <= timeout_hit_s;
                end else begin
                    m0_rdata_r <= s_ready ? s_rdata : {DATA_W{1'b0}};
                    m0_err_r   <= timeout_hit_s;
                end
            end
        end
    end

    assign s_valid  = s_valid_r;
    assign s_addr   = s_addr_r;
    assign s_wdata  = s_wdata_r;
    assign s_wstrb  = s_wstrb_r;
    assign grant    = grant_r;
    assign m0_ready = ready_r[M_CPU];
    assign m1_ready = ready_r[M_LOADER];
    assign m0_rdata = m0_rdata_r;
    assign m1_rdata = m1_rdata_r;
    assign m0_err   = m0_err_r;
    assign m1_err   = m1_err_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: table-driven vectors plus
// hand-written sequences for wait states, timeout and mid-transaction reset.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic        rst;
        logic        m0_v;
        logic [31:0] m0_a;
        logic        m1_v;
        logic [31:0] m1_a;
        logic        s_rdy;
        logic [31:0] s_rd;
        logic        e_sv;
        logic [1:0]  e_gnt;
        logic [31:0] e_saddr;
        logic        e_r0;
        logic        e_r1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic        e_err0;
        logic        e_err1;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_valid (m0_valid),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_wstrb (m0_wstrb),
        .m0_ready (m0_ready),
        .m0_rdata (m0_rdata),
        .m0_err   (m0_err),
        .m1_valid (m1_valid),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_wstrb (m1_wstrb),
        .m1_ready (m1_ready),
        .m1_rdata (m1_rdata),
        .m1_err   (m1_err),
        .s_valid  (s_valid),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_ready  (s_ready),
        .s_rdata  (s_rdata),
        .grant    (grant)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Advance one clock; outputs are then sampled 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hard stop if the run ever wedges.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        int pulses;
        bit got;

        //            rst  m0v  m0_a         m1v  m1_a         rdy  s_rd          sv   gnt    saddr        r0   r1   rd0           rd1           e0   e1
        vecs[0]  = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 2'b00, 32'h0,       1'b0, 1'b0, 32'h0,       32'h0,       1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'h100,     1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 2'b01, 32'h100,     1'b0, 1'b0, 32'h0,       32'h0,       1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h100,     1'b0, 32'h0,       1'b1, 32'hCAFEBABE, 1'b0, 2'b01, 32'h100,     1'b1, 1'b0, 32'hCAFEBABE, 32'h0,       1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h100,     1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 2'b00, 32'h100,     1'b0, 1'b0, 32'hCAFEBABE, 32'h0,       1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 2'b00, 32'h100,     1'b0, 1'b0, 32'hCAFEBABE, 32'h0,       1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 2'b00, 32'h0,       1'b0, 1'b0, 32'h0,       32'h0,       1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h200,     1'b1, 32'h300,     1'b0, 32'h0,       1'b1, 2'b01, 32'h200,     1'b0, 1'b0, 32'h0,       32'h0,       1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h200,     1'b1, 32'h300,     1'b1, 32'h11111111, 1'b0, 2'b01, 32'h200,     1'b1, 1'b0, 32'h11111111, 32'h0,       1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h200,     1'b1, 32'h300,     1'b0, 32'h0,       1'b0, 2'b00, 32'h200,     1'b0, 1'b0, 32'h11111111, 32'h0,       1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h200,     1'b1, 32'h300,     1'b0, 32'h0,       1'b1, 2'b10, 32'h300,     1'b0, 1'b0, 32'h11111111, 32'h0,       1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'h200,     1'b1, 32'h300,     1'b1, 32'h22222222, 1'b0, 2'b10, 32'h300,     1'b0, 1'b1, 32'h11111111, 32'h22222222, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'h200,     1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 2'b00, 32'h300,     1'b0, 1'b0, 32'h11111111, 32'h22222222, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 32'h200,     1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 2'b01, 32'h200,     1'b0, 1'b0, 32'h11111111, 32'h22222222, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'h200,     1'b0, 32'h0,       1'b1, 32'h33333333, 1'b0, 2'b01, 32'h200,     1'b1, 1'b0, 32'h33333333, 32'h22222222, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 2'b00, 32'h200,     1'b0, 1'b0, 32'h33333333, 32'h22222222, 1'b0, 1'b0};

        reset    = 1'b1;
        m0_valid = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
        m1_valid = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
        s_ready  = 1'b0; s_rdata = 32'h0;
        tick();
        tick();

        // ---------------- table: single read, contention, round-robin ----
        for (int i = 0; i < NV; i++) begin
            reset    = vecs[i].rst;
            m0_valid = vecs[i].m0_v;
            m0_addr  = vecs[i].m0_a;
            m1_valid = vecs[i].m1_v;
            m1_addr  = vecs[i].m1_a;
            s_ready  = vecs[i].s_rdy;
            s_rdata  = vecs[i].s_rd;
            tick();
            chk($sformatf("v%0d s_valid", i),  32'(s_valid),  32'(vecs[i].e_sv));
            chk($sformatf("v%0d grant", i),    32'(grant),    32'(vecs[i].e_gnt));
            chk($sformatf("v%0d s_addr", i),   s_addr,        vecs[i].e_saddr);
            chk($sformatf("v%0d m0_ready", i), 32'(m0_ready), 32'(vecs[i].e_r0));
            chk($sformatf("v%0d m1_ready", i), 32'(m1_ready), 32'(vecs[i].e_r1));
            chk($sformatf("v%0d m0_rdata", i), m0_rdata,      vecs[i].e_rd0);
            chk($sformatf("v%0d m1_rdata", i), m1_rdata,      vecs[i].e_rd1);
            chk($sformatf("v%0d m0_err", i),   32'(m0_err),   32'(vecs[i].e_err0));
            chk($sformatf("v%0d m1_err", i),   32'(m1_err),   32'(vecs[i].e_err1));
        end

        // ---------------- m1 write with 5 wait states ----------------------
        m1_valid = 1'b1; m1_addr = 32'h2000; m1_wdata = 32'h12345678; m1_wstrb = 4'b0011;
        s_ready  = 1'b0; s_rdata = 32'h0;
        pulses   = 0;
        tick();
        chk("wr s_valid", 32'(s_valid), 32'd1);
        chk("wr grant",   32'(grant),   32'd2);
        // Payload changes after grant must not reach the slave.
        m1_addr = 32'hFFFF0000; m1_wdata = 32'hDEADBEEF; m1_wstrb = 4'b1111;
        for (int w = 0; w < 5; w++) begin
            tick();
            pulses += int'(m1_ready);
            chk($sformatf("wr wait%0d s_valid", w), 32'(s_valid), 32'd1);
            chk($sformatf("wr wait%0d s_addr", w),  s_addr,       32'h2000);
            chk($sformatf("wr wait%0d s_wdata", w), s_wdata,      32'h12345678);
            chk($sformatf("wr wait%0d s_wstrb", w), 32'(s_wstrb), 32'h3);
        end
        s_ready = 1'b1; s_rdata = 32'hAAAA5555;
        tick();
        pulses += int'(m1_ready);
        chk("wr m1_ready", 32'(m1_ready), 32'd1);
        chk("wr m1_err",   32'(m1_err),   32'd0);
        chk("wr m1_rdata", m1_rdata,      32'hAAAA5555);
        chk("wr m0_ready", 32'(m0_ready), 32'd0);
        s_ready = 1'b0; m1_valid = 1'b0;
        for (int w = 0; w < 3; w++) begin
            tick();
            pulses += int'(m1_ready);
        end
        chk("wr pulse count", 32'(pulses), 32'd1);
        chk("wr grant idle",  32'(grant),  32'd0);

        // ---------------- timeout with silent slave ------------------------
        m0_valid = 1'b1; m0_addr = 32'h400; s_ready = 1'b0; s_rdata = 32'h5A5A5A5A;
        tick();
        chk("to s_valid rise", 32'(s_valid), 32'd1);
        n   = 0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            n++;
            if (m0_ready) got = 1'b1;
        end
        chk("to latency", 32'(n),        32'd9);
        chk("to m0_err",  32'(m0_err),   32'd1);
        chk("to m0_rdata", m0_rdata,     32'h0);
        chk("to s_valid", 32'(s_valid),  32'd0);
        m0_valid = 1'b0;
        tick();
        chk("to grant idle", 32'(grant), 32'd0);
        chk("to ready drop", 32'(m0_ready), 32'd0);

        // ---------------- s_ready on the expiry cycle wins -----------------
        m0_valid = 1'b1; m0_addr = 32'h500;
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("edge wait%0d m0_ready", k), 32'(m0_ready), 32'd0);
        end
        s_ready = 1'b1; s_rdata = 32'h600D600D;
        tick();
        chk("edge m0_ready", 32'(m0_ready), 32'd1);
        chk("edge m0_err",   32'(m0_err),   32'd0);
        chk("edge m0_rdata", m0_rdata,      32'h600D600D);
        s_ready = 1'b0; m0_valid = 1'b0;
        tick();

        // ---------------- asynchronous reset during BUSY -------------------
        m1_valid = 1'b1; m1_addr = 32'h3000; m1_wdata = 32'h0; m1_wstrb = 4'h0;
        tick();
        chk("rst pre s_valid", 32'(s_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst async s_valid", 32'(s_valid), 32'd0);
        chk("rst async grant",   32'(grant),   32'd0);
        chk("rst async m1_ready", 32'(m1_ready), 32'd0);
        chk("rst async m0_ready", 32'(m0_ready), 32'd0);
        m1_valid = 1'b0;
        tick();
        tick();
        chk("rst held m1_ready", 32'(m1_ready), 32'd0);
        reset = 1'b0;
        m1_valid = 1'b1; m1_addr = 32'h4000;
        tick();
        chk("post rst s_valid", 32'(s_valid), 32'd1);
        chk("post rst grant",   32'(grant),   32'd2);
        chk("post rst s_addr",  s_addr,       32'h4000);
        s_ready = 1'b1; s_rdata = 32'h0BADF00D;
        tick();
        chk("post rst m1_ready", 32'(m1_ready), 32'd1);
        chk("post rst m1_rdata", m1_rdata,      32'h0BADF00D);
        s_ready = 1'b0; m1_valid = 1'b0;
        tick();
        chk("post rst grant idle", 32'(grant),    32'd0);
        chk("post rst ready drop", 32'(m1_ready), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
